// File: rtl/fft_spectrum_bars_if.sv
// fft_spectrum_bars_if: FFT magnitude stream (bin address, magnitude, valid, last-of-frame).
interface fft_spectrum_bars_if #(
    parameter int MAG_W  = 24,
    parameter int ADDR_W = 9
);
    logic [ADDR_W-1:0] i_fft_addr;
    logic [MAG_W-1:0]  i_fft_mag;
    logic              i_fft_valid;
    logic              i_fft_last;
    modport master(output i_fft_addr, i_fft_mag, i_fft_valid, i_fft_last);
    modport slave(input i_fft_addr, i_fft_mag, i_fft_valid, i_fft_last);
endinterface

// File: rtl/fft_spectrum_bars.sv
// fft_spectrum_bars: scales FFT bins into double-buffered bars and renders them as VGA colour (2-cycle latency).
// Optional peak-hold markers are enabled by defining PEAK_HOLD_EN.
module fft_spectrum_bars #(
    parameter int MAG_W           = 24,
    parameter int ADDR_W          = 9,
    parameter int MAG_SCALE_SHIFT = 10,
    parameter int SCREEN_HEIGHT   = 480,
    parameter int BINS_PER_BAR    = 4,
    parameter int NUM_BARS        = 64,
    parameter int BAR_WIDTH       = 8,
    parameter int BAR_GAP         = 1,
    parameter int X_OFFSET        = 64,
    parameter int PEAK_DECAY_DIV  = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_reset_n,
    fft_spectrum_bars_if.slave   fft,
    input  logic [9:0]           pixel_x,
    input  logic [9:0]           pixel_y,
    input  logic                 video_on,
    output logic [9:0]           o_vga_r,
    output logic [9:0]           o_vga_g,
    output logic [9:0]           o_vga_b,
    output logic                 o_frame_done
);
    localparam int HW  = $clog2(SCREEN_HEIGHT + 1);
    localparam int BW  = $clog2(NUM_BARS);
    localparam int BBS = $clog2(BINS_PER_BAR);
    localparam int BWS = $clog2(BAR_WIDTH);
    localparam logic [29:0] WHITE = 30'h3FFF_FFFF;
    localparam logic [29:0] BLUE  = 30'h0000_03FF;
    localparam logic [29:0] RED   = 30'h3FF0_0000;

    if (BAR_GAP >= BAR_WIDTH || PEAK_DECAY_DIV < 1) begin : g_cfg_err
        $error("fft_spectrum_bars: BAR_GAP must be < BAR_WIDTH and PEAK_DECAY_DIV >= 1");
    end

    logic [HW-1:0]       r_h [2][NUM_BARS];
    logic [NUM_BARS-1:0] r_t [2];
    logic                r_sel;
    logic                r_done;
    logic [9:0]          r_s1_y;
    logic                r_s1_vo;
    logic                r_s1_mg;
    logic                r_s1_gap;
    logic [HW-1:0]       r_s1_h;
    logic [29:0]         r_rgb;

    logic [MAG_W-1:0]  w_shift;
    logic [HW-1:0]     w_h;
    logic [ADDR_W-1:0] w_abar;
    logic [BW-1:0]     w_bar;
    logic              w_hit;
    logic              w_commit;
    logic              w_wb;
    logic [HW-1:0]     w_merge;
    logic [9:0]        w_rel;
    logic [BW-1:0]     w_pbar;
    logic              w_mg;
    logic              w_gap;
    logic [9:0]        w_top;
    logic              w_red;
    logic [29:0]       w_rgb;

    // Clamp is done on the full-width shifted value so large magnitudes never wrap.
    assign w_shift  = fft.i_fft_mag >> MAG_SCALE_SHIFT;
    assign w_h      = (w_shift > MAG_W'(SCREEN_HEIGHT)) ? HW'(SCREEN_HEIGHT) : HW'(w_shift);
    assign w_abar   = fft.i_fft_addr >> BBS;
    assign w_bar    = BW'(w_abar);
    assign w_hit    = fft.i_fft_valid && (w_abar < ADDR_W'(NUM_BARS));
    assign w_commit = fft.i_fft_valid && fft.i_fft_last;
    assign w_wb     = ~r_sel;
    assign w_merge  = (!r_t[w_wb][w_bar] || w_h > r_h[w_wb][w_bar]) ? w_h : r_h[w_wb][w_bar];

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            for (int b = 0; b < NUM_BARS; b++) begin
                r_h[0][b] <= '0;
                r_h[1][b] <= '0;
            end
            r_t[0] <= '0;
            r_t[1] <= '0;
            r_sel  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (w_hit) begin
                r_h[w_wb][w_bar] <= w_merge;
                r_t[w_wb][w_bar] <= 1'b1;
            end
            if (w_commit) begin
                r_t[r_sel] <= '0;
                r_sel      <= w_wb;
            end
            r_done <= w_commit;
        end
    end

    assign w_rel  = pixel_x - 10'(X_OFFSET);
    assign w_pbar = BW'(w_rel >> BWS);
    assign w_mg   = (pixel_x < 10'(X_OFFSET)) || ((w_rel >> BWS) >= 10'(NUM_BARS));
    assign w_gap  = w_rel[BWS-1:0] >= BWS'(BAR_WIDTH - BAR_GAP);

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_s1_y   <= '0;
            r_s1_vo  <= 1'b0;
            r_s1_mg  <= 1'b0;
            r_s1_gap <= 1'b0;
            r_s1_h   <= '0;
            r_rgb    <= '0;
        end else begin
            r_s1_y   <= pixel_y;
            r_s1_vo  <= video_on;
            r_s1_mg  <= w_mg;
            r_s1_gap <= w_gap;
            r_s1_h   <= r_t[r_sel][w_pbar] ? r_h[r_sel][w_pbar] : '0;
            r_rgb    <= w_rgb;
        end
    end

`ifdef PEAK_HOLD_EN
    localparam int CW = (PEAK_DECAY_DIV > 1) ? $clog2(PEAK_DECAY_DIV) : 1;
    logic [HW-1:0] r_pk [NUM_BARS];
    logic [CW-1:0] r_dc [NUM_BARS];
    logic [HW-1:0] r_s1_pk;
    logic [HW-1:0] w_newh [NUM_BARS];

    // Height each bar will display after this commit, including the bin merged in the same cycle.
    always_comb begin
        for (int b = 0; b < NUM_BARS; b++) begin
            w_newh[b] = (w_hit && w_bar == BW'(b)) ? w_merge : (r_t[w_wb][b] ? r_h[w_wb][b] : '0);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            for (int b = 0; b < NUM_BARS; b++) begin
                r_pk[b] <= '0;
                r_dc[b] <= '0;
            end
            r_s1_pk <= '0;
        end else begin
            if (w_commit) begin
                for (int b = 0; b < NUM_BARS; b++) begin
                    if (w_newh[b] >= r_pk[b]) begin
                        r_pk[b] <= w_newh[b];
                        r_dc[b] <= '0;
                    end else if (r_dc[b] == CW'(PEAK_DECAY_DIV - 1)) begin
                        r_pk[b] <= r_pk[b] - HW'(1);
                        r_dc[b] <= '0;
                    end else begin
                        r_dc[b] <= r_dc[b] + CW'(1);
                    end
                end
            end
            r_s1_pk <= r_pk[w_pbar];
        end
    end

    assign w_red = (r_s1_pk != '0) && (r_s1_y == 10'(SCREEN_HEIGHT) - 10'(r_s1_pk));
`else
    assign w_red = 1'b0;
`endif

    assign w_top = 10'(SCREEN_HEIGHT) - 10'(r_s1_h);
    assign w_rgb = !r_s1_vo ? 30'd0 : (r_s1_mg || r_s1_gap) ? WHITE : w_red ? RED : (r_s1_y >= w_top) ? BLUE : WHITE;

    assign {o_vga_r, o_vga_g, o_vga_b} = r_rgb;
    assign o_frame_done = r_done;
endmodule

// File: tb/tb_fft_spectrum_bars.sv
// tb_fft_spectrum_bars: directed checks of bar ingest, double-buffered commit and pixel rendering.
module tb_fft_spectrum_bars;
    localparam logic [29:0] WHITE = 30'h3FFF_FFFF;
    localparam logic [29:0] BLUE  = 30'h0000_03FF;
    localparam logic [29:0] RED   = 30'h3FF0_0000;
    localparam logic [29:0] BLACK = 30'h0;

    logic       sys_clk = 1'b0;
    logic       sys_reset_n;
    logic [9:0] pixel_x, pixel_y;
    logic       video_on;
    logic [9:0] o_vga_r, o_vga_g, o_vga_b;
    logic       o_frame_done;
    logic [29:0] w_rgb;
    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;

    fft_spectrum_bars_if #(.MAG_W(24), .ADDR_W(9)) fft_if ();

    fft_spectrum_bars dut (
        .sys_clk      (sys_clk),
        .sys_reset_n  (sys_reset_n),
        .fft          (fft_if.slave),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .video_on     (video_on),
        .o_vga_r      (o_vga_r),
        .o_vga_g      (o_vga_g),
        .o_vga_b      (o_vga_b),
        .o_frame_done (o_frame_done)
    );

    always #5 sys_clk = ~sys_clk;
    assign w_rgb = {o_vga_r, o_vga_g, o_vga_b};
    always @(posedge sys_clk) if (o_frame_done) n_done++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bin(input int a, input int m, input logic l);
        fft_if.i_fft_addr  = 9'(a);
        fft_if.i_fft_mag   = 24'(m);
        fft_if.i_fft_valid = 1'b1;
        fft_if.i_fft_last  = l;
        @(posedge sys_clk);
        #1;
        fft_if.i_fft_valid = 1'b0;
        fft_if.i_fft_last  = 1'b0;
    endtask

    task automatic pix(input int x, input int y, input logic vo);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = vo;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pchk(input string tag, input int x, input int y, input logic [29:0] exp);
        pix(x, y, 1'b1);
        check($sformatf("%s x=%0d y=%0d", tag, x, y), {2'b0, w_rgb}, {2'b0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int xs [6];
        logic [29:0] ex [6];
        logic hist [10];
        xs = '{64, 72, 64, 64, 72, 67};
        ex = '{BLUE, WHITE, BLUE, WHITE, BLUE, WHITE};
        sys_reset_n = 1'b0;
        fft_if.i_fft_addr = '0;
        fft_if.i_fft_mag = '0;
        fft_if.i_fft_valid = 1'b0;
        fft_if.i_fft_last = 1'b0;
        pixel_x = 10'd60;
        pixel_y = 10'd0;
        video_on = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset rgb", {2'b0, w_rgb}, 32'h0);
        check("reset done", {31'b0, o_frame_done}, 32'h0);
        sys_reset_n = 1'b1;
        @(posedge sys_clk);
        #1;
        // frame 1: bar0 saturates at 480, bar1 = 200
        bin(0, 100 << 10, 1'b0);
        bin(1, 600 << 10, 1'b0);
        bin(2, 50 << 10, 1'b0);
        bin(3, 0, 1'b0);
        for (int a = 4; a < 8; a++) bin(a, 200 << 10, a == 7);
        @(posedge sys_clk);
        #1;
        check("frame1 done count", n_done, 1);
        for (int x = 60; x <= 80; x++)
            pchk("scan y400", x, 400, (x < 64 || x == 71 || x >= 79) ? WHITE : BLUE);
        pchk("y250 bar0", 64, 250, BLUE);
        pchk("y250 bar1", 72, 250, WHITE);
        pchk("y250 bar2", 80, 250, WHITE);
        pchk("bar0 top row", 64, 0, BLUE);
        pchk("bar1 edge in", 72, 280, BLUE);
        pchk("bar1 edge out", 72, 279, WHITE);
        check("done single pulse", n_done, 1);
        // video_on latency
        pix(64, 400, 1'b1);
        check("vo steady", {2'b0, w_rgb}, {2'b0, BLUE});
        video_on = 1'b0;
        @(posedge sys_clk);
        #1;
        check("vo lag1", {2'b0, w_rgb}, {2'b0, BLUE});
        @(posedge sys_clk);
        #1;
        check("vo lag2", {2'b0, w_rgb}, {2'b0, BLACK});
        for (int k = 0; k < 10; k++) begin
            video_on = 1'((k + 1) & 1);
            hist[k] = video_on;
            @(posedge sys_clk);
            #1;
            if (k >= 1) check($sformatf("vo toggle %0d", k), {2'b0, w_rgb}, {2'b0, hist[k-1] ? BLUE : BLACK});
        end
        // frame 2 ingested while scanning; commit at c=2 (bin 256 is out of range but carries last)
        video_on = 1'b1;
        pixel_y = 10'd250;
        for (int c = 0; c < 7; c++) begin
            if (c < 6) pixel_x = 10'(xs[c]);
            fft_if.i_fft_valid = (c < 3);
            fft_if.i_fft_last  = (c == 2);
            fft_if.i_fft_addr  = (c == 0) ? 9'd0 : (c == 1) ? 9'd4 : 9'd256;
            fft_if.i_fft_mag   = (c == 0) ? 24'(100 << 10) : (c == 1) ? 24'(400 << 10) : 24'(600 << 10);
            @(posedge sys_clk);
            #1;
            if (c >= 1) check($sformatf("midline c=%0d", c - 1), {2'b0, w_rgb}, {2'b0, ex[c-1]});
        end
        fft_if.i_fft_valid = 1'b0;
        fft_if.i_fft_last = 1'b0;
        check("frame2 done count", n_done, 2);
        // frame 3: stale bank values must not leak; clamp at full width (517 -> 480)
        bin(1, 50 << 10, 1'b0);
        bin(12, 517 << 10, 1'b1);
        pchk("f3 bar0 out", 64, 429, WHITE);
        pchk("f3 bar0 in", 64, 430, BLUE);
        pchk("f3 bar1 untouched", 72, 479, WHITE);
        pchk("f3 bar3 clamp", 88, 0, BLUE);
        pchk("f3 bar3 gap", 95, 0, WHITE);
        // reset mid-ingest
        pchk("pre-reset margin", 60, 10, WHITE);
        bin(0, 300 << 10, 1'b0);
        bin(1, 300 << 10, 1'b0);
        bin(2, 300 << 10, 1'b0);
        #2;
        sys_reset_n = 1'b0;
        #1;
        check("async reset rgb", {2'b0, w_rgb}, 32'h0);
        check("async reset done", {31'b0, o_frame_done}, 32'h0);
        @(posedge sys_clk);
        #1;
        sys_reset_n = 1'b1;
        bin(8, 100 << 10, 1'b1);
        pchk("post-reset bar2 in", 80, 380, BLUE);
        pchk("post-reset bar2 out", 80, 379, WHITE);
        pchk("post-reset bar2 last col", 86, 380, BLUE);
        pchk("post-reset bar2 gap", 87, 380, WHITE);
        pchk("post-reset bar0", 64, 479, WHITE);
        pchk("post-reset bar1", 72, 479, WHITE);
        // peak hold: bar0 = 300 then empty frames
        bin(0, 300 << 10, 1'b1);
`ifdef PEAK_HOLD_EN
        pchk("peak row", 64, 180, RED);
`else
        pchk("no peak row", 64, 180, BLUE);
`endif
        pchk("below peak", 64, 181, BLUE);
        pchk("above peak", 64, 179, WHITE);
        for (int f = 0; f < 4; f++) bin(0, 0, 1'b1);
`ifdef PEAK_HOLD_EN
        pchk("peak decay4", 64, 181, RED);
`else
        pchk("no peak decay4", 64, 181, WHITE);
`endif
        pchk("zero bar4", 64, 180, WHITE);
        for (int f = 0; f < 4; f++) bin(0, 0, 1'b1);
`ifdef PEAK_HOLD_EN
        pchk("peak decay8", 64, 182, RED);
`else
        pchk("no peak decay8", 64, 182, WHITE);
`endif
        pchk("zero bar8", 64, 181, WHITE);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fft_spectrum_bars.md
# fft_spectrum_bars

Single-clock spectrum bar renderer: takes the FFT magnitude stream, scales and saturates each bin, and groups bins into parametrised bars. Completed frames are double-buffered and the block answers VGA pixel queries with RGB colour after a fixed 2-cycle pipeline. It replaces the one-bin-per-column visualiser in the FFT-to-VGA path with configurable bar count and width, frame-atomic updates and optional peak-hold markers.

## Interface
- MAG_W, 24, FFT magnitude width
- ADDR_W, 9, FFT bin address width
- MAG_SCALE_SHIFT, 10, right shift applied to magnitude
- SCREEN_HEIGHT, 480, active lines; also the height clamp
- BINS_PER_BAR, 4, bins merged per bar (power of two)
- NUM_BARS, 64, bars stored/drawn
- BAR_WIDTH, 8, pixel columns per bar slot (power of two)
- BAR_GAP, 1, trailing white columns inside each slot (< BAR_WIDTH)
- X_OFFSET, 64, first column of bar 0
- PEAK_DECAY_DIV, 4, commits per 1-pixel peak decay (PEAK_HOLD_EN only)
- sys_clk  in  1  single clock, all logic rising-edge
- sys_reset_n  in  1  asynchronous, active-low reset
- i_fft_addr  in  ADDR_W  bin index
- i_fft_mag  in  MAG_W  bin magnitude
- i_fft_valid  in  1  bin qualifier
- i_fft_last  in  1  last bin of frame, sampled only with i_fft_valid
- pixel_x, pixel_y  in  10 each  current pixel coordinate
- video_on  in  1  active-area flag
- o_vga_r, o_vga_g, o_vga_b  out  10 each  pixel colour, registered
- o_frame_done  out  1  one-cycle pulse after each commit

## Operation
- Height: h = min(i_fft_mag >> MAG_SCALE_SHIFT, SCREEN_HEIGHT). Compute at full MAG_W width, then clamp; no truncation before the compare.
- Bar index = i_fft_addr / BINS_PER_BAR. Bins with index >= NUM_BARS are ignored, but their i_fft_last still commits.
- Two banks (write, display), each holding NUM_BARS heights plus a NUM_BARS-bit touched vector.
- Ingest into the write bank:
  - first bin of a bar in the frame stores h and sets touched;
  - later bins store max(old, h);
  - bins may arrive in any order.
- Commit on i_fft_valid && i_fft_last, after that bin is merged:
  - swap banks;
  - clear the new write bank's touched vector in the same cycle;
  - o_frame_done pulses the next cycle.
- A display bar whose touched bit is 0 renders as height 0.
- Render, with rel = pixel_x - X_OFFSET:
  - video_on=0: black (all 0).
  - pixel_x < X_OFFSET, bar ≥ NUM_BARS, or (rel mod BAR_WIDTH) ≥ BAR_WIDTH-BAR_GAP: white (all 3FF).
  - Otherwise, with bar = rel / BAR_WIDTH: blue (r=g=0, b=3FF) if pixel_y ≥ SCREEN_HEIGHT - h, else white.
- Reset: all heights, touched bits, peaks and decay counters = 0; bank select = 0; RGB = 0; o_frame_done = 0.

## Timing
- Render latency: 2 cycles.
  - Stage 1 registers x/y/video_on plus bar index/gap/margin flags and issues the height read.
  - Stage 2 compares and registers RGB.
- Colour at cycle n+2 corresponds to the inputs at cycle n.
- Commit in cycle n: pixels whose stage-1 read occurs at cycle ≤ n use the old display bank; reads at n+1 onward use the new bank.
- Ingest and render run concurrently every cycle with no stalls. i_fft_valid may be high continuously, including back-to-back frames (last followed immediately by bin 0 of the next frame).
- i_fft_last without i_fft_valid: ignored.
- Reset asserted mid-frame or mid-line: partial frame discarded; outputs 0 asynchronously. The first commit after release shows only bins received after release.

## Configuration
- PEAK_HOLD_EN defined:
  - per-bar peak register updated at each commit: if new height ≥ peak, peak = new height and that bar's decay counter resets; else every PEAK_DECAY_DIV commits peak decrements by 1, floor 0;
  - pixel with pixel_y == SCREEN_HEIGHT - peak and peak > 0 (non-gap bar column) renders red (r=3FF, g=b=0), overriding blue/white;
  - latency unchanged.
- PEAK_HOLD_EN undefined: no peak registers or counters; red never output.

## Test plan
- Reset, then bins 0–3 = {100,600,50,0}<<10, 4–7 = 200<<10, last on bin 7; y=400, scan x=60..80 -> x 60..63 white; 64..70 blue (bar0 = 480, saturated); 71 white (gap); 72..78 blue (bar1 = 200); 79 white. o_frame_done pulses once.
- Same frame, y=250 -> bar0 blue, bar1 white (250 < 280); bars 2+ white (untouched = 0).
- video_on=0 at x=64 -> RGB 0 exactly 2 cycles later; toggle video_on each cycle -> output toggles with 2-cycle lag.
- Second frame sent while scanning; commit mid-line -> columns before the switch point match old heights, later columns match new; no mixed bars inside one frame's data.
- Reset pulse mid-ingest (bins 0–2 written) -> RGB 0 immediately. After release, frame with only bin 8 = 100<<10 plus last -> bar2 = 100, all others 0.
- PEAK_HOLD_EN: frame bar0 = 300, then frames bar0 = 0 ×8 -> red row at y=180, moving to y=182 after 8 commits (decay every 4).
